// File: rtl/psm_pkg.sv
// psm_pkg: shared timing defaults, counter width, state types and the
// expected-result helpers used by the PSM host and its testbench.
package psm_pkg;

  localparam int TIME_OP1_DEF = 3;
  localparam int TIME_OP2_DEF = 1;
  localparam int TIME_OP3_DEF = 8;
  localparam int WDOG_CYC_DEF = 32;
  localparam int CNT_W        = 5;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_START = 3'd1,
    SEQ_OP1   = 3'd2,
    SEQ_OP2   = 3'd3,
    SEQ_OP3   = 3'd4,
    SEQ_READY = 3'd5
  } t_seq_state;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    PH1    = 3'd2,
    PH2    = 3'd3,
    PH3    = 3'd4,
    DONE   = 3'd5
  } t_host_state;

  function automatic logic [7:0] exp_or(input logic [7:0] a, input logic [7:0] b);
    return a | b;
  endfunction

  function automatic logic [7:0] exp_xor(input logic [7:0] a, input logic [7:0] b);
    return a ^ b;
  endfunction

  function automatic logic [7:0] exp_op3(input logic [7:0] a, input logic [7:0] b);
    return ~(~a & b);
  endfunction

endpackage

// File: rtl/psm_phase_cnt.sv
// psm_phase_cnt: 5-bit cycle counter with synchronous clear that saturates
// at its maximum value instead of wrapping.
module psm_phase_cnt
  import psm_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: clear wins, then increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 5'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) count_q <= {CNT_W{1'b0}};
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/psm_host.sv
// psm_host: launches one operand pair on the phased sequencer, collects the
// three phase results and returns them with a watchdog-backed error flag.
// Define PSM_HOST_CHECK_EN to add phase-length, protocol and result checks.
module psm_host
  import psm_pkg::*;
#(
  parameter int TIME_OP1 = TIME_OP1_DEF,
  parameter int TIME_OP2 = TIME_OP2_DEF,
  parameter int TIME_OP3 = TIME_OP3_DEF,
  parameter int WDOG_CYC = WDOG_CYC_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [7:0] ReqA,
  input  logic [7:0] ReqB,
  output logic       Start,
  output logic [7:0] Din1,
  output logic [7:0] Din2,
  input  logic       Ready,
  input  logic       Op1,
  input  logic       Op2,
  input  logic       Op3,
  input  logic [7:0] Dout,
  output logic       RspValid,
  input  logic       RspReady,
  output logic [7:0] RspOr,
  output logic [7:0] RspXor,
  output logic [7:0] RspOp3,
  output logic       RspErr
);

  t_host_state      state_q, state_d;
  logic             req_ready_s, accept_s, in_op_s, timeout_s, chk_s;
  logic             inc1_s, inc2_s, inc3_s, smp_or_s, smp_xor_s, smp_op3_s;
  logic [CNT_W-1:0] cnt1_s, cnt2_s, cnt3_s, wd_cnt_s;
  logic             start_q, start_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]       din1_q, din1_d, din2_q, din2_d;
  logic [7:0]       rsp_or_q, rsp_or_d, rsp_xor_q, rsp_xor_d, rsp_op3_q, rsp_op3_d;

  // Gated by Reset so ReqReady stays low while the block is held in reset.
  assign req_ready_s = Reset && (state_q == IDLE) && Ready;
  assign accept_s    = ReqValid && req_ready_s;
  assign in_op_s     = (state_q == LAUNCH) || (state_q == PH1) ||
                       (state_q == PH2) || (state_q == PH3);
  assign timeout_s   = in_op_s && ((int'(wd_cnt_s) + 1) >= WDOG_CYC);

  // A phase counts from the cycle its OpN first appears, even while the FSM
  // is still in the previous phase state taking the transition.
  assign inc1_s    = (state_q == PH1) && Op1;
  assign inc2_s    = ((state_q == PH1) || (state_q == PH2)) && Op2;
  assign inc3_s    = ((state_q == PH2) || (state_q == PH3)) && Op3;
  assign smp_or_s  = inc1_s && (cnt1_s == 5'd0);
  assign smp_xor_s = inc2_s && (cnt2_s == 5'd0);
  assign smp_op3_s = inc3_s && (cnt3_s == 5'd0);

  psm_phase_cnt u_cnt1 (.Clock(Clock), .Reset(Reset), .clear(accept_s), .inc(inc1_s),  .count(cnt1_s));
  psm_phase_cnt u_cnt2 (.Clock(Clock), .Reset(Reset), .clear(accept_s), .inc(inc2_s),  .count(cnt2_s));
  psm_phase_cnt u_cnt3 (.Clock(Clock), .Reset(Reset), .clear(accept_s), .inc(inc3_s),  .count(cnt3_s));
  psm_phase_cnt u_wdog (.Clock(Clock), .Reset(Reset), .clear(accept_s), .inc(in_op_s), .count(wd_cnt_s));

  // FSM state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; the watchdog overrides every operating state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = LAUNCH; else state_d = IDLE;
      LAUNCH:  if (timeout_s) state_d = DONE; else state_d = PH1;
      PH1:     if (timeout_s) state_d = DONE; else if (Op2) state_d = PH2; else state_d = PH1;
      PH2:     if (timeout_s) state_d = DONE; else if (Op3) state_d = PH3; else state_d = PH2;
      PH3:     if (timeout_s || Ready) state_d = DONE; else state_d = PH3;
      DONE:    if (RspReady) state_d = IDLE; else state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

`ifdef PSM_HOST_CHECK_EN
  logic after_start_q, after_start_d;
  logic len_err_s, seq_err_s, dout_err_s;

  // Protocol, phase-length and result checks against the captured operands.
  always_comb begin
    after_start_d = start_q;
    len_err_s  = ((state_q == PH1) && Op2 && (int'(cnt1_s) != TIME_OP1)) ||
                 ((state_q == PH2) && Op3 && (int'(cnt2_s) != TIME_OP2)) ||
                 ((state_q == PH3) && Ready && (int'(cnt3_s) != TIME_OP3));
    seq_err_s  = (after_start_q && !Op1) ||
                 (in_op_s && ((Op1 && Op2) || (Op1 && Op3) || (Op2 && Op3))) ||
                 (((state_q == PH1) || (state_q == PH2)) && Ready);
    dout_err_s = (smp_or_s  && (Dout != exp_or(din1_q, din2_q))) ||
                 (smp_xor_s && (Dout != exp_xor(din1_q, din2_q))) ||
                 (smp_op3_s && (Dout != exp_op3(din1_q, din2_q)));
    chk_s = len_err_s || seq_err_s || dout_err_s;
  end

  // Delayed Start, marking the cycle in which Op1 must be high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) after_start_q <= 1'b0;
    else        after_start_q <= after_start_d;
  end
`else
  assign chk_s = 1'b0;
`endif

  // FSM outputs: capture on accept, sample phase results, latch errors.
  always_comb begin
    start_d     = accept_s;
    rsp_valid_d = (state_d == DONE);
    din1_d      = din1_q;
    din2_d      = din2_q;
    rsp_or_d    = rsp_or_q;
    rsp_xor_d   = rsp_xor_q;
    rsp_op3_d   = rsp_op3_q;
    rsp_err_d   = rsp_err_q;
    if (accept_s) begin
      din1_d    = ReqA;
      din2_d    = ReqB;
      rsp_or_d  = 8'h00;
      rsp_xor_d = 8'h00;
      rsp_op3_d = 8'h00;
      rsp_err_d = 1'b0;
    end else begin
      if (smp_or_s)  rsp_or_d  = Dout; else rsp_or_d  = rsp_or_q;
      if (smp_xor_s) rsp_xor_d = Dout; else rsp_xor_d = rsp_xor_q;
      if (smp_op3_s) rsp_op3_d = Dout; else rsp_op3_d = rsp_op3_q;
      if (timeout_s || chk_s) rsp_err_d = 1'b1; else rsp_err_d = rsp_err_q;
    end
  end

  // Output registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      din1_q      <= 8'h00;
      din2_q      <= 8'h00;
      rsp_or_q    <= 8'h00;
      rsp_xor_q   <= 8'h00;
      rsp_op3_q   <= 8'h00;
    end else begin
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      rsp_or_q    <= rsp_or_d;
      rsp_xor_q   <= rsp_xor_d;
      rsp_op3_q   <= rsp_op3_d;
    end
  end

  assign ReqReady = req_ready_s;
  assign Start    = start_q;
  assign Din1     = din1_q;
  assign Din2     = din2_q;
  assign RspValid = rsp_valid_q;
  assign RspOr    = rsp_or_q;
  assign RspXor   = rsp_xor_q;
  assign RspOp3   = rsp_op3_q;
  assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_psm_host.sv
// tb_psm_host: directed bench for psm_host with a behavioural sequencer and a
// scoreboard of expected responses; honours PSM_HOST_CHECK_EN like the RTL.
module tb_psm_host;
  import psm_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset, ReqValid, ReqReady, Start, Ready, Op1, Op2, Op3;
  logic       RspValid, RspReady, RspErr;
  logic [7:0] ReqA, ReqB, Din1, Din2, Dout, RspOr, RspXor, RspOp3;

  typedef struct {
    logic [7:0] o;
    logic [7:0] x;
    logic [7:0] p;
    logic       e;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   start_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  psm_host dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqA(ReqA), .ReqB(ReqB), .Start(Start), .Din1(Din1), .Din2(Din2),
    .Ready(Ready), .Op1(Op1), .Op2(Op2), .Op3(Op3), .Dout(Dout),
    .RspValid(RspValid), .RspReady(RspReady), .RspOr(RspOr), .RspXor(RspXor),
    .RspOp3(RspOp3), .RspErr(RspErr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [63:0] reset_vec();
    return 64'({Start, Din1, Din2, ReqReady, RspValid, RspOr, RspXor, RspOp3, RspErr});
  endfunction

  // One request through the behavioural sequencer; l1/l2/l3 are the OpN
  // lengths, hang stops the sequencer after Op1 and never raises Ready.
  task automatic txn(input logic [7:0] a, input logic [7:0] b, input int l1,
                     input int l2, input int l3, input bit hang, input int hold,
                     input bit tie);
    exp_t e, q;
    int   k;
    bit   seen;
    e.o   = (l1 > 0) ? (a | b) : 8'h00;
    e.x   = (l2 > 0) ? (a ^ b) : 8'h00;
    e.p   = (l3 > 0) ? (a | ~b) : 8'h00;
    e.e   = hang;
`ifdef PSM_HOST_CHECK_EN
    if (l1 != TIME_OP1_DEF || l2 != TIME_OP2_DEF || l3 != TIME_OP3_DEF) e.e = 1'b1;
`endif
    e.lat = hang ? 33 : (l1 + l2 + l3 + 3);
    k = 0;
    while (ReqReady !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk("req_ready", 64'(ReqReady), 64'd1);
    ReqValid = 1'b1;
    ReqA     = a;
    ReqB     = b;
    sb.push_back(e);
    tick();
    ReqValid = 1'b0;
    ReqA     = 8'($urandom);
    ReqB     = 8'($urandom);
    Ready    = 1'b0;
    start_cyc.push_back(cyc);
    chk("launch", 64'({Start, Din1, Din2}), 64'({1'b1, a, b}));
    seen = 1'b0;
    k    = 1;
    while (!seen && k < 45) begin
      tick();
      k++;
      Op1   = (k >= 2) && (k < 2 + l1);
      Op2   = (k >= 2 + l1) && (k < 2 + l1 + l2);
      Op3   = (k >= 2 + l1 + l2) && (k < 2 + l1 + l2 + l3);
      Ready = !hang && (k >= 2 + l1 + l2 + l3);
      Dout  = Op1 ? (a | b) : Op2 ? (a ^ b) : Op3 ? (a | ~b) : 8'($urandom);
      if (k == 2) chk("start_once", 64'({Start, Din1, Din2}), 64'({1'b0, a, b}));
      if (RspValid === 1'b1) seen = 1'b1;
    end
    Op1   = 1'b0;
    Op2   = 1'b0;
    Op3   = 1'b0;
    Ready = 1'b1;
    chk("rsp_latency", 64'(k), 64'(e.lat));
    chk("no_req_in_done", 64'(ReqReady), 64'd0);
    if (sb.size() > 0) begin
      q = sb.pop_front();
      chk("rsp_payload", 64'({RspOr, RspXor, RspOp3, RspErr}), 64'({q.o, q.x, q.p, q.e}));
      if (!tie) begin
        for (int i = 0; i < hold; i++) begin
          tick();
          chk("rsp_hold", 64'({RspValid, RspOr, RspXor, RspOp3, RspErr}),
              64'({1'b1, q.o, q.x, q.p, q.e}));
        end
        RspReady = 1'b1;
        tick();
        RspReady = 1'b0;
      end else begin
        tick();
      end
    end else begin
      chk("sb_underflow", 64'(sb.size()), 64'd1);
    end
    chk("rsp_drop", 64'(RspValid), 64'd0);
  endtask

  initial begin
    int hi;
    Reset = 1'b0; ReqValid = 1'b0; ReqA = 8'h00; ReqB = 8'h00; Ready = 1'b1;
    Op1 = 1'b0; Op2 = 1'b0; Op3 = 1'b0; Dout = 8'h00; RspReady = 1'b0;
    tick();
    tick();
    chk("reset_outputs", reset_vec(), 64'd0);
    Ready = 1'b0;
    Reset = 1'b1;
    tick();
    chk("ready_low_no_req", 64'(ReqReady), 64'd0);
    Ready = 1'b1;
    #1;
    chk("first_ready_req", 64'(ReqReady), 64'd1);

    txn(8'h5A, 8'h0F, TIME_OP1_DEF, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 0, 1'b0);
    txn(8'h00, 8'hFF, TIME_OP1_DEF, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 5, 1'b0);
    txn(8'hC3, 8'h3C, TIME_OP1_DEF, 0, 0, 1'b1, 1, 1'b0);
    txn(8'h12, 8'h34, 4, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 0, 1'b0);

    // Abort in PH3 with reset; no response may follow.
    ReqValid = 1'b1; ReqA = 8'h66; ReqB = 8'h99;
    tick();
    ReqValid = 1'b0;
    Ready    = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      Op1  = (k <= 4);
      Op2  = (k == 5);
      Op3  = (k >= 6);
      Dout = Op1 ? 8'hFF : Op2 ? 8'hFF : 8'h66;
    end
    Reset = 1'b0;
    #1;
    chk("abort_reset_vals", reset_vec(), 64'd0);
    Op3 = 1'b0;
    Ready = 1'b1;
    tick();
    chk("abort_reset_held", reset_vec(), 64'd0);
    Reset = 1'b1;
    #1;
    chk("abort_release_req", 64'(ReqReady), 64'd1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (RspValid !== 1'b0) hi++;
    end
    chk("abort_no_rsp", 64'(hi), 64'd0);
    txn(8'hA5, 8'h5A, TIME_OP1_DEF, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 0, 1'b0);

    // Back-to-back with RspReady tied high.
    start_cyc.delete();
    RspReady = 1'b1;
    txn(8'h81, 8'h7E, TIME_OP1_DEF, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 0, 1'b1);
    txn(8'hFE, 8'h01, TIME_OP1_DEF, TIME_OP2_DEF, TIME_OP3_DEF, 1'b0, 0, 1'b1);
    RspReady = 1'b0;
    if (start_cyc.size() == 2) begin
      chk("start_gap", 64'((start_cyc[1] - start_cyc[0]) >= 15), 64'd1);
    end else begin
      chk("start_count", 64'(start_cyc.size()), 64'd2);
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

endmodule
